// File: rtl/counter_seg7_display_pkg.sv
// -----------------------------------------------------------------------------
// counter_seg7_display_pkg
//   Shared constants for the 0..12 up/down counter and its 7-segment display
//   stage.
//   - MAX_VAL / ERR_CODE : legal counter range and the "error" code. The
//                          upstream counter reuses both constants.
//   - GLYPH_*            : active-low segment patterns, bit order {g,f,e,d,c,b,a}.
//   - GC_*               : 5-bit glyph codes that the display selects between.
//                          Codes 0..9 are the decimal digits themselves.
// -----------------------------------------------------------------------------
package counter_seg7_display_pkg;

  // Counter value range
  localparam int MAX_VAL  = 12;
  localparam int ERR_CODE = 15;

  // Segment patterns, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_U     = 7'b1000001;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Glyph codes; 0..9 select the matching decimal digit
  localparam logic [4:0] GC_E     = 5'd10;
  localparam logic [4:0] GC_R     = 5'd11;
  localparam logic [4:0] GC_U     = 5'd12;
  localparam logic [4:0] GC_D     = 5'd13;
  localparam logic [4:0] GC_DASH  = 5'd14;
  localparam logic [4:0] GC_BLANK = 5'd15;

  // Glyph code for a single decimal digit (0..9)
  function automatic logic [4:0] digit_code(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/counter_seg7_display_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
//   Combinational glyph decoder: 5-bit glyph code -> 7-bit active-low segments.
//   Ports:
//     code_i  in  5  glyph code (0..9 digits, GC_E/GC_R/GC_U/GC_D/GC_DASH/GC_BLANK)
//     seg_o   out 7  segments {g,f,e,d,c,b,a}, active-low
//   Unused codes decode to blank so a stray code never lights random segments.
// -----------------------------------------------------------------------------
module seg7_glyph
  import counter_seg7_display_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (code_i)
      5'd0:    seg_o = GLYPH_0;
      5'd1:    seg_o = GLYPH_1;
      5'd2:    seg_o = GLYPH_2;
      5'd3:    seg_o = GLYPH_3;
      5'd4:    seg_o = GLYPH_4;
      5'd5:    seg_o = GLYPH_5;
      5'd6:    seg_o = GLYPH_6;
      5'd7:    seg_o = GLYPH_7;
      5'd8:    seg_o = GLYPH_8;
      5'd9:    seg_o = GLYPH_9;
      GC_E:    seg_o = GLYPH_E;
      GC_R:    seg_o = GLYPH_R;
      GC_U:    seg_o = GLYPH_U;
      GC_D:    seg_o = GLYPH_D;
      GC_DASH: seg_o = GLYPH_DASH;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/counter_seg7_display.sv
// -----------------------------------------------------------------------------
// counter_seg7_display
//   Display stage for the 0..12 up/down counter. Drives a 4-digit multiplexed
//   common-anode 7-segment display:
//     d3 = direction glyph ('U' up / 'd' down), d2 = blank,
//     d1 = tens (blank when zero), d0 = ones.
//   Values 13/14 show '-' '-' in d1/d0. Error code 15 shows a blinking "Err".
//   The displayed value/direction are captured once per scan frame so that a
//   digit never changes while it is being scanned.
//
//   Parameters:
//     DIV_W    each digit is lit for 2**DIV_W clk cycles
//     BLINK_W  error blink toggles every 2**BLINK_W clk cycles
//     MAX_VAL  largest legal counter value
//     ERR_CODE counter value meaning "error"
//   Ports:
//     clk     in   1  system clock
//     rst     in   1  asynchronous, active-high reset
//     in_val  in   4  counter value (0..MAX_VAL or ERR_CODE)
//     in_dir  in   1  counter direction (1 = up, 0 = down)
//     an      out  4  digit anodes, active-low one-hot; an[0] = rightmost digit
//     seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//     dp      out  1  decimal point, active-low, always off
// -----------------------------------------------------------------------------
module counter_seg7_display #(
  parameter int DIV_W    = 15,
  parameter int BLINK_W  = 25,
  parameter int MAX_VAL  = counter_seg7_display_pkg::MAX_VAL,
  parameter int ERR_CODE = counter_seg7_display_pkg::ERR_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_val,
  input  logic       in_dir,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  import counter_seg7_display_pkg::*;

  localparam logic [3:0] MAX_V4 = 4'(MAX_VAL);
  localparam logic [3:0] ERR_V4 = 4'(ERR_CODE);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W+1:0] scan_q,  scan_d;
  logic [BLINK_W:0] blink_q, blink_d;
  logic [3:0]       disp_val_q, disp_val_d;
  logic             disp_dir_q, disp_dir_d;
  logic             disp_err_q, disp_err_d;
  logic [3:0]       an_q,  an_d;
  logic [6:0]       seg_q, seg_d;

  // ---------------------------------------------------------------------------
  // Scan / blink timing
  // ---------------------------------------------------------------------------
  logic [1:0] digit_idx;
  logic       frame_end;
  logic       blink_on;

  assign digit_idx = scan_q[DIV_W+1:DIV_W];
  // Last cycle of the frame (digit 3 about to hand over to digit 0)
  assign frame_end = &scan_q;
  assign blink_on  = ~blink_q[BLINK_W];

  assign scan_d  = scan_q + (DIV_W+2)'(1);
  assign blink_d = blink_q + (BLINK_W+1)'(1);

  // ---------------------------------------------------------------------------
  // Frame latch: input is sampled only at the frame boundary
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dir_d = disp_dir_q;
    disp_err_d = disp_err_q;
    if (frame_end) begin
      disp_val_d = in_val;
      disp_dir_d = in_dir;
      disp_err_d = (in_val == ERR_V4);
    end
  end

  // ---------------------------------------------------------------------------
  // Binary -> tens/ones. Legal values never exceed 12, so tens is 0 or 1 and
  // a single compare replaces a divider.
  // ---------------------------------------------------------------------------
  logic       val_legal;
  logic       tens;
  logic [3:0] ones;

  assign val_legal = (disp_val_q <= MAX_V4);
  assign tens      = (disp_val_q >= 4'd10);
  assign ones      = tens ? (disp_val_q - 4'd10) : disp_val_q;

  // ---------------------------------------------------------------------------
  // Digit content mux -> glyph code
  // ---------------------------------------------------------------------------
  logic [4:0] code;
  logic [4:0] dir_code;

  assign dir_code = disp_dir_q ? GC_U : GC_D;

  always_comb begin
    code = GC_BLANK;
    case (digit_idx)
      2'd0: begin
        if (disp_err_q)     code = GC_BLANK;
        else if (val_legal) code = digit_code(ones);
        else                code = GC_DASH;
      end
      2'd1: begin
        if (disp_err_q)     code = GC_R;
        else if (val_legal) code = tens ? digit_code(4'd1) : GC_BLANK;
        else                code = GC_DASH;
      end
      2'd2: begin
        code = disp_err_q ? GC_R : GC_BLANK;
      end
      default: begin
        code = disp_err_q ? GC_E : dir_code;
      end
    endcase
  end

  logic [6:0] glyph_seg;

  seg7_glyph u_glyph (
    .code_i (code),
    .seg_o  (glyph_seg)
  );

  // ---------------------------------------------------------------------------
  // Output next-state. During the dark half of the error blink every anode is
  // off; seg is also blanked so nothing stale is driven onto the bus.
  // ---------------------------------------------------------------------------
  logic blank_all;

  assign blank_all = disp_err_q & ~blink_on;

  always_comb begin
    an_d  = ~(4'b0001 << digit_idx);
    seg_d = glyph_seg;
    if (blank_all) begin
      an_d  = 4'b1111;
      seg_d = GLYPH_BLANK;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. an and seg share one edge so digits never ghost into each other.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q     <= '0;
      blink_q    <= '0;
      disp_val_q <= 4'd0;
      disp_dir_q <= 1'b1;
      disp_err_q <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= GLYPH_BLANK;
    end else begin
      scan_q     <= scan_d;
      blink_q    <= blink_d;
      disp_val_q <= disp_val_d;
      disp_dir_q <= disp_dir_d;
      disp_err_q <= disp_err_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_counter_seg7_display.sv
// -----------------------------------------------------------------------------
// tb_counter_seg7_display
//   Self-checking bench for counter_seg7_display with DIV_W=2, BLINK_W=4
//   (4 clk per digit, 16 clk per frame, blink half-period 16 clk).
//   A behavioural model computes the expected an/seg for every clock from the
//   number of edges since reset release and the value latched per frame;
//   directed literal checks pin the model at chosen edges.
// -----------------------------------------------------------------------------
module tb_counter_seg7_display;

  localparam int DIV_W     = 2;
  localparam int BLINK_W   = 4;
  localparam int DIGIT_CYC = 1 << DIV_W;
  localparam int FRAME_CYC = 4 * DIGIT_CYC;
  localparam int BLINK_CYC = 1 << BLINK_W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_val;
  logic       in_dir;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  counter_seg7_display #(
    .DIV_W   (DIV_W),
    .BLINK_W (BLINK_W),
    .MAX_VAL (12),
    .ERR_CODE(15)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_val (in_val),
    .in_dir (in_dir),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and glyph table
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  logic [6:0] glyph_tab [0:15];
  localparam int G_E = 10, G_R = 11, G_U = 12, G_D = 13, G_DASH = 14, G_BLANK = 15;

  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0000110; glyph_tab[11] = 7'b0101111;
    glyph_tab[12] = 7'b1000001; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0111111; glyph_tab[15] = 7'b1111111;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: k = clock edges since reset release
  // ---------------------------------------------------------------------------
  int   k     = 0;
  int   m_val = 0;
  logic m_dir = 1'b1;

  function automatic void model_out(input int kk, input int v, input logic dir,
                                    output logic [3:0] ea, output logic [6:0] es);
    int   idx;
    logic on;
    int   dir_g;
    idx   = ((kk - 1) / DIGIT_CYC) % 4;
    on    = (((kk - 1) / BLINK_CYC) % 2) == 0;
    dir_g = dir ? G_U : G_D;
    ea    = ~(4'b0001 << idx);
    if (v == 15) begin
      if (!on) begin
        ea = 4'b1111;
        es = glyph_tab[G_BLANK];
      end else begin
        case (idx)
          0:       es = glyph_tab[G_BLANK];
          3:       es = glyph_tab[G_E];
          default: es = glyph_tab[G_R];
        endcase
      end
    end else if (v > 12) begin
      case (idx)
        3:       es = glyph_tab[dir_g];
        2:       es = glyph_tab[G_BLANK];
        default: es = glyph_tab[G_DASH];
      endcase
    end else begin
      case (idx)
        0:       es = glyph_tab[v % 10];
        1:       es = (v >= 10) ? glyph_tab[v / 10] : glyph_tab[G_BLANK];
        2:       es = glyph_tab[G_BLANK];
        default: es = glyph_tab[dir_g];
      endcase
    end
  endfunction

  // Compare process: every clock, model vs DUT, plus the invariants
  initial begin
    logic       s_rst;
    logic [3:0] s_val;
    logic       s_dir;
    logic [3:0] ea;
    logic [6:0] es;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_val = in_val;
      s_dir = in_dir;
      ea    = 4'b1111;
      es    = 7'b1111111;
      if (s_rst) begin
        k     = 0;
        m_val = 0;
        m_dir = 1'b1;
      end else begin
        k++;
        model_out(k, m_val, m_dir, ea, es);
        if (k % FRAME_CYC == 0) begin
          m_val = int'(s_val);
          m_dir = s_dir;
        end
      end
      #1;
      chk("model_an", an, ea);
      chk("model_seg", seg, es);
      chk("an_onehot", (an == 4'b1111) || $onehot(~an), 1);
      chk("dp_off", dp, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      fails++;
      tests++;
      $display("FAIL wait_k: got k=%0d expected %0d (timeout)", k, target);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es);
    chk({name, "_an"}, an, ea);
    chk({name, "_seg"}, seg, es);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed literals
  // ---------------------------------------------------------------------------
  initial begin
    rst    = 1'b1;
    in_val = 4'd0;
    in_dir = 1'b1;
    #1;
    lit("in_reset", 4'b1111, 7'b1111111);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset frame: '0', blank, blank, 'U'
    wait_k(1);  lit("f0_d0", 4'b1110, 7'b1000000);
    wait_k(5);  lit("f0_d1", 4'b1101, 7'b1111111);
    wait_k(9);  lit("f0_d2", 4'b1011, 7'b1111111);
    wait_k(13); lit("f0_d3", 4'b0111, 7'b1000001);
    in_val = 4'd12; in_dir = 1'b0;

    // 12 down: '2', '1', blank, 'd'
    wait_k(17); lit("v12_d0", 4'b1110, 7'b0100100);
    wait_k(21); lit("v12_d1", 4'b1101, 7'b1111001);
    wait_k(25); lit("v12_d2", 4'b1011, 7'b1111111);
    wait_k(29); lit("v12_d3", 4'b0111, 7'b0100001);
    in_val = 4'd5; in_dir = 1'b1;

    // 5 latched; change to 7 mid-frame must not show until next frame
    wait_k(33); lit("v5_d0", 4'b1110, 7'b0010010);
    wait_k(34); in_val = 4'd7;
    wait_k(36); lit("v5_hold", 4'b1110, 7'b0010010);
    wait_k(49); lit("v7_d0", 4'b1110, 7'b1111000);
    in_val = 4'd15;

    // Error: lit frame (blink on), then dark frame
    wait_k(65); lit("err_d0", 4'b1110, 7'b1111111);
    wait_k(69); lit("err_d1", 4'b1101, 7'b0101111);
    wait_k(77); lit("err_d3", 4'b0111, 7'b0000110);
    wait_k(85); lit("err_dark", 4'b1111, 7'b1111111);
    wait_k(100); in_val = 4'd13;

    // Illegal 13: dashes, direction glyph kept
    wait_k(113); lit("v13_d0", 4'b1110, 7'b0111111);
    wait_k(117); lit("v13_d1", 4'b1101, 7'b0111111);
    wait_k(125); lit("v13_d3", 4'b0111, 7'b1000001);
    in_val = 4'd15;

    // Reset mid-frame inside the error display
    wait_k(129); lit("err2_d0", 4'b1110, 7'b1111111);
    wait_k(134);
    #1 rst = 1'b1;
    #1 lit("rst_mid", 4'b1111, 7'b1111111);
    in_val = 4'd4; in_dir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_k(1);  lit("post_d0", 4'b1110, 7'b1000000);
    wait_k(13); lit("post_d3", 4'b0111, 7'b1000001);
    wait_k(17); lit("v4_d0", 4'b1110, 7'b0011001);
    wait_k(29); lit("v4_d3", 4'b0111, 7'b0100001);
    wait_k(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
